// File: rtl/conv_coef_ctrl.sv
// Coefficient controller for the 5x5 convolution filter: shadow bank written from the
// control port, copied to the active bank on the first rising rx_vs after a commit.
module conv_coef_ctrl #(
  parameter int COEF_W  = 8,
  parameter int NTAPS   = 25,
  parameter int SHIFT_W = 4,
  parameter int SUM_W   = 13
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [4:0]                cfg_addr,
  input  logic [COEF_W-1:0]         cfg_data,
  input  logic                      cfg_commit,
  input  logic                      rx_vs,
  output logic [NTAPS*COEF_W-1:0]   coef_bus,
  output logic [SHIFT_W-1:0]        shift_out,
  output logic [SUM_W-1:0]          coef_sum,
  output logic                      pending,
  output logic                      swap_done,
  output logic                      cfg_err
);

  localparam int          ID_TAP     = NTAPS / 2;
  localparam logic [4:0]  SHIFT_ADDR = 5'(NTAPS);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t              state;
  logic [COEF_W-1:0]   shadow_reg [NTAPS];
  logic [COEF_W-1:0]   active_reg [NTAPS];
  logic [SHIFT_W-1:0]  shadow_shift_reg;
  logic                vs_d;

  logic                vs_rise;
  logic                wr_accept;
  logic                wr_tap;
  logic                wr_shift;
  logic                wr_bad;
  logic [COEF_W-1:0]   old_tap;
  logic [SUM_W-1:0]    old_ext;
  logic [SUM_W-1:0]    new_ext;

  assign cfg_ready = (state == IDLE);
  assign vs_rise   = rx_vs & ~vs_d;
  assign wr_accept = cfg_valid & cfg_ready;
  assign wr_tap    = wr_accept && (cfg_addr < SHIFT_ADDR);
  assign wr_shift  = wr_accept && (cfg_addr == SHIFT_ADDR);
  assign wr_bad    = wr_accept && (cfg_addr > SHIFT_ADDR);

  always_comb begin
    old_tap = '0;
    if (cfg_addr < SHIFT_ADDR) old_tap = shadow_reg[cfg_addr];
  end

  // Incremental sum update: the full range of 25 signed taps fits SUM_W exactly.
  assign old_ext = {{(SUM_W-COEF_W){old_tap[COEF_W-1]}}, old_tap};
  assign new_ext = {{(SUM_W-COEF_W){cfg_data[COEF_W-1]}}, cfg_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NTAPS; i++) begin
        shadow_reg[i] <= (i == ID_TAP) ? COEF_W'(1) : '0;
        active_reg[i] <= (i == ID_TAP) ? COEF_W'(1) : '0;
      end
      shadow_shift_reg <= '0;
      shift_out        <= '0;
      coef_sum         <= SUM_W'(1);
      pending          <= 1'b0;
      swap_done        <= 1'b0;
      cfg_err          <= 1'b0;
      state            <= IDLE;
      vs_d             <= 1'b0;
    end else begin
      vs_d      <= rx_vs;
      swap_done <= 1'b0;
      cfg_err   <= 1'b0;
      if (state == IDLE) begin
        if (wr_tap) begin
          shadow_reg[cfg_addr] <= cfg_data;
          coef_sum             <= coef_sum - old_ext + new_ext;
        end
        if (wr_shift) shadow_shift_reg <= cfg_data[SHIFT_W-1:0];
        if (wr_bad) cfg_err <= 1'b1;
        // A frame edge seen while idle is deliberately not a swap trigger.
        if (cfg_commit) begin
          state   <= PENDING;
          pending <= 1'b1;
        end
      end else if (vs_rise) begin
        for (int i = 0; i < NTAPS; i++) active_reg[i] <= shadow_reg[i];
        shift_out <= shadow_shift_reg;
        swap_done <= 1'b1;
        pending   <= 1'b0;
        state     <= IDLE;
      end
    end
  end

  for (genvar gi = 0; gi < NTAPS; gi++) begin : g_bus
    assign coef_bus[gi*COEF_W +: COEF_W] = active_reg[gi];
  end

endmodule

// File: tb/tb_conv_coef_ctrl.sv
// Self-checking bench for conv_coef_ctrl: a reference model predicts every cycle and
// committed kernels are queued, then matched against each swap_done pulse.
module tb_conv_coef_ctrl;

  localparam int COEF_W = 8, NTAPS = 25, SHIFT_W = 4, SUM_W = 13;
  localparam int PW = NTAPS*COEF_W + SHIFT_W;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    cfg_valid = 1'b0;
  logic                    cfg_ready;
  logic [4:0]              cfg_addr = '0;
  logic [COEF_W-1:0]       cfg_data = '0;
  logic                    cfg_commit = 1'b0;
  logic                    rx_vs = 1'b0;
  logic [NTAPS*COEF_W-1:0] coef_bus;
  logic [SHIFT_W-1:0]      shift_out;
  logic [SUM_W-1:0]        coef_sum;
  logic                    pending, swap_done, cfg_err;

  conv_coef_ctrl #(.COEF_W(COEF_W), .NTAPS(NTAPS), .SHIFT_W(SHIFT_W), .SUM_W(SUM_W)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_commit(cfg_commit), .rx_vs(rx_vs),
    .coef_bus(coef_bus), .shift_out(shift_out), .coef_sum(coef_sum),
    .pending(pending), .swap_done(swap_done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [COEF_W-1:0]  m_sh [NTAPS];
  logic [SHIFT_W-1:0] m_shift;
  logic [SUM_W-1:0]   m_sum;
  logic               m_pend;
  logic               m_vsd;
  logic [PW-1:0]      m_active;
  logic [PW-1:0]      sb_q [$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [SUM_W-1:0] sx(input logic [COEF_W-1:0] x);
    return {{(SUM_W-COEF_W){x[COEF_W-1]}}, x};
  endfunction

  function automatic logic [PW-1:0] pack_model();
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < NTAPS; i++) p[i*COEF_W +: COEF_W] = m_sh[i];
    p[PW-1 -: SHIFT_W] = m_shift;
    return p;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NTAPS; i++) m_sh[i] = (i == 12) ? 8'h01 : 8'h00;
    m_shift  = '0;
    m_sum    = 13'd1;
    m_pend   = 1'b0;
    m_vsd    = 1'b0;
    m_active = pack_model();
    sb_q.delete();
  endfunction

  // Scoreboard consumer: each swap_done must match the oldest committed kernel.
  always @(negedge clk) begin
    if (!rst && swap_done) begin
      if (sb_q.size() == 0) chk("swap_unexpected", 1, 0);
      else begin
        m_active = sb_q.pop_front();
        chk("swap_bus", {shift_out, coef_bus}, m_active);
      end
    end
  end

  task automatic check_state(input string tag);
    chk({tag, "_bus"}, {shift_out, coef_bus}, m_active);
    chk({tag, "_sum"}, coef_sum, m_sum);
    chk({tag, "_pend"}, pending, m_pend);
    chk({tag, "_ready"}, cfg_ready, !m_pend);
  endtask

  // One clock: drive, let the edge pass, update the model, compare.
  task automatic step(input logic v, input logic [4:0] a, input logic [7:0] d,
                      input logic c, input logic vs, input string tag);
    logic rise, exp_err, exp_swap;
    cfg_valid = v; cfg_addr = a; cfg_data = d; cfg_commit = c; rx_vs = vs;
    @(negedge clk);
    #1;
    rise = vs & ~m_vsd;
    m_vsd = vs;
    exp_err = 1'b0;
    exp_swap = 1'b0;
    if (!m_pend) begin
      if (v) begin
        if (a < 5'd25) begin
          m_sum = m_sum - sx(m_sh[a]) + sx(d);
          m_sh[a] = d;
        end else if (a == 5'd25) m_shift = d[SHIFT_W-1:0];
        else exp_err = 1'b1;
      end
      if (c) begin
        m_pend = 1'b1;
        sb_q.push_back(pack_model());
      end
    end else if (rise) begin
      exp_swap = 1'b1;
      m_pend = 1'b0;
    end
    chk({tag, "_err"}, cfg_err, exp_err);
    chk({tag, "_swap"}, swap_done, exp_swap);
    check_state(tag);
    $display("step %-10s v=%0b a=%0d d=%02h c=%0b vs=%0b sum=%0h pend=%0b swap=%0b err=%0b",
             tag, v, a, d, c, vs, coef_sum, pending, swap_done, cfg_err);
    cfg_valid = 1'b0;
    cfg_commit = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cfg_valid = 1'b0; cfg_commit = 1'b0; rx_vs = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_state("reset");
    chk("reset_swap", swap_done, 0);
    chk("reset_err", cfg_err, 0);
  endtask

  task automatic idle(input int n, input logic vs, input string tag);
    for (int i = 0; i < n; i++) step(0, 5'd0, 8'h00, 0, vs, tag);
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("reset_tap12", coef_bus[12*COEF_W +: COEF_W], 8'h01);

    // Write then commit, frame edge 100 cycles later.
    step(1, 5'd0, 8'hFD, 0, 0, "wr_t0");
    step(1, 5'd24, 8'h05, 0, 0, "wr_t24");
    chk("sum_is_3", coef_sum, 13'd3);
    step(0, 5'd0, 8'h00, 1, 0, "commit");
    idle(100, 0, "wait");
    step(0, 5'd0, 8'h00, 0, 1, "vs_rise");
    chk("tap0_after", coef_bus[0 +: COEF_W], 8'hFD);
    chk("tap24_after", coef_bus[24*COEF_W +: COEF_W], 8'h05);
    idle(2, 0, "post_swap");

    // Boundary coefficients on the centre tap, from identity.
    do_reset();
    step(1, 5'd12, 8'h7F, 0, 0, "t12_7f");
    chk("sum_127", coef_sum, 13'd127);
    step(1, 5'd12, 8'h80, 0, 0, "t12_80");
    chk("sum_m128", coef_sum, 13'h1F80);

    // Writes are refused while pending, accepted after the swap.
    step(0, 5'd0, 8'h00, 1, 0, "commit2");
    step(1, 5'd3, 8'h09, 0, 0, "wr_pend");
    step(1, 5'd3, 8'h09, 1, 0, "wr_pend2");
    step(0, 5'd0, 8'h00, 0, 1, "vs_rise2");
    step(0, 5'd0, 8'h00, 0, 0, "vs_low2");
    step(1, 5'd3, 8'h09, 0, 0, "wr_after");

    // Invalid address and the shift register.
    step(1, 5'd27, 8'h44, 0, 0, "bad_addr");
    step(0, 5'd0, 8'h00, 0, 0, "err_clear");
    step(1, 5'd25, 8'h06, 1, 0, "wr_shift");
    idle(3, 0, "wait_sh");
    step(0, 5'd0, 8'h00, 0, 1, "vs_sh");
    chk("shift_6", shift_out, 4'd6);
    idle(2, 0, "post_sh");

    // Commit coincident with a frame edge waits for the next edge.
    step(1, 5'd7, 8'h21, 0, 0, "wr_t7");
    step(0, 5'd0, 8'h00, 1, 1, "commit_vs");
    idle(3, 1, "vs_hi");
    idle(2, 0, "vs_lo");
    step(0, 5'd0, 8'h00, 0, 1, "vs_next");
    idle(2, 0, "post_cv");

    // Commit while rx_vs is already high.
    step(1, 5'd20, 8'hC0, 0, 1, "wr_t20_hi");
    step(0, 5'd0, 8'h00, 1, 1, "commit_hi");
    idle(4, 1, "still_hi");
    idle(2, 0, "fall");
    step(0, 5'd0, 8'h00, 0, 1, "rise_again");
    idle(2, 0, "post_hi");

    // Reset while pending drops both the commit and the shadow writes.
    step(1, 5'd5, 8'h11, 0, 0, "wr_t5");
    step(0, 5'd0, 8'h00, 1, 0, "commit_rst");
    idle(2, 0, "pend_rst");
    do_reset();
    chk("rst_pend_sum", coef_sum, 13'd1);
    idle(2, 0, "after_rst");
    step(0, 5'd0, 8'h00, 0, 1, "vs_after_rst");
    idle(3, 0, "quiet");

    chk("queue_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
